plic_target_arbiter: RTL and testbench

- Per-target selection stage directly downstream of the per-source gateways.
- Takes each source's interrupt-pending bit, enable bit and priority, and selects the highest-priority eligible source above the target threshold.
- Drives the target's interrupt request.
- Runs the claim/complete handshake, returning one-cycle claim and complete strobes to the originating gateway.

---
 rtl/plic_target_arbiter.sv | 132 +++++++++++++
 tb/tb_plic_target_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/plic_target_arbiter.sv
// PLIC per-target arbiter: selects the highest-priority pending, enabled source and runs claim/complete.
// Optional `define PLIC_ARB_CLAIM_TRACK_EN drops completes for IDs that were never claimed.
// The priority input is named prio because "priority" is a SystemVerilog keyword.
module plic_target_arbiter #(
  parameter int SOURCES    = 16,
  parameter int PRIORITIES = 8,
  localparam int PRI_BITS  = $clog2(PRIORITIES),
  localparam int ID_BITS   = $clog2(SOURCES + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SOURCES-1:0]           ip,
  input  logic [SOURCES-1:0]           ie,
  input  logic [SOURCES*PRI_BITS-1:0]  prio,
  input  logic [PRI_BITS-1:0]          threshold,
  output logic                         irq,
  output logic [ID_BITS-1:0]           best_id,
  input  logic                         claim_req,
  output logic [ID_BITS-1:0]           claim_id,
  output logic                         claim_vld,
  input  logic                         complete_req,
  input  logic [ID_BITS-1:0]           complete_id,
  output logic [SOURCES-1:0]           claim,
  output logic [SOURCES-1:0]           complete
);

  typedef enum logic [1:0] {IDLE, FLUSH1, FLUSH2} state_e;

  state_e              state_q, state_d;
  logic [PRI_BITS-1:0] eff_pri_q [SOURCES];
  logic [PRI_BITS-1:0] threshold_q;
  logic [PRI_BITS-1:0] best_pri;
  logic [ID_BITS-1:0]  best_id_d, best_id_q;
  logic                above_thr_q;
  logic [SOURCES-1:0]  claim_d, complete_d;
  logic [ID_BITS-1:0]  claim_id_d;

  // Stage 1: mask priorities by pending & enable; threshold travels alongside.
  // NOTE: every flop uses <= so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SOURCES; i++) eff_pri_q[i] <= '0;
      threshold_q <= '0;
    end else begin
      for (int i = 0; i < SOURCES; i++)
        eff_pri_q[i] <= (ip[i] && ie[i]) ? prio[i*PRI_BITS +: PRI_BITS] : '0;
      threshold_q <= threshold;
    end
  end

  // Strict '>' while scanning upward keeps the lowest ID on ties and leaves ID 0 for max 0.
  // NOTE: defaults first so no path through the block leaves a variable unassigned (no latch).
  always_comb begin
    best_pri  = '0;
    best_id_d = '0;
    for (int i = 0; i < SOURCES; i++) begin
      if (eff_pri_q[i] > best_pri) begin
        best_pri  = eff_pri_q[i];
        best_id_d = ID_BITS'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_id_q   <= '0;
      above_thr_q <= 1'b0;
    end else begin
      best_id_q   <= best_id_d;
      above_thr_q <= best_pri > threshold_q;
    end
  end

  assign best_id = best_id_q;
  assign irq     = above_thr_q && (state_q == IDLE);

  // FLUSH holds irq low while the claimed source's dropped ip works through both stages.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (claim_req) state_d = FLUSH1;
      FLUSH1:  state_d = FLUSH2;
      FLUSH2:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

`ifdef PLIC_ARB_CLAIM_TRACK_EN
  logic [SOURCES-1:0] claimed_q;
`endif

  always_comb begin
    claim_id_d = (claim_req && irq) ? best_id_q : '0;
    claim_d    = '0;
    complete_d = '0;
    for (int i = 0; i < SOURCES; i++) begin
      claim_d[i]    = claim_req && irq && (best_id_q == ID_BITS'(i + 1));
      complete_d[i] = complete_req && (complete_id == ID_BITS'(i + 1));
`ifdef PLIC_ARB_CLAIM_TRACK_EN
      complete_d[i] = complete_d[i] && claimed_q[i];
`endif
    end
  end

`ifdef PLIC_ARB_CLAIM_TRACK_EN
  // A claim in the same cycle as a complete of the same ID wins: the bit stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) claimed_q <= '0;
    else        claimed_q <= (claimed_q & ~complete_d) | claim_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      claim_vld <= 1'b0;
      claim_id  <= '0;
      claim     <= '0;
      complete  <= '0;
    end else begin
      claim_vld <= claim_req;
      claim_id  <= claim_id_d;
      claim     <= claim_d;
      complete  <= complete_d;
    end
  end

endmodule

// File: tb/tb_plic_target_arbiter.sv
// Self-checking bench for plic_target_arbiter; strobe expectations go through a scoreboard queue.
// Define PLIC_ARB_CLAIM_TRACK_EN for both bench and RTL to exercise the claim-tracking build.
module tb_plic_target_arbiter;
  localparam int SOURCES  = 16;
  localparam int PRI_BITS = 3;
  localparam int ID_BITS  = 5;
`ifdef PLIC_ARB_CLAIM_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  typedef struct {
    logic               vld;
    logic [ID_BITS-1:0] id;
    logic [SOURCES-1:0] clm;
    logic [SOURCES-1:0] cmp;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [SOURCES-1:0]          ip, ie;
  logic [SOURCES*PRI_BITS-1:0] prio;
  logic [PRI_BITS-1:0]         threshold;
  logic                        irq, claim_vld, claim_req, complete_req;
  logic [ID_BITS-1:0]          best_id, claim_id, complete_id;
  logic [SOURCES-1:0]          claim, complete;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  plic_target_arbiter dut (
    .clk(clk), .rst_n(rst_n), .ip(ip), .ie(ie), .prio(prio), .threshold(threshold),
    .irq(irq), .best_id(best_id), .claim_req(claim_req), .claim_id(claim_id),
    .claim_vld(claim_vld), .complete_req(complete_req), .complete_id(complete_id),
    .claim(claim), .complete(complete)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [SOURCES-1:0] onehot(input int id);
    logic [SOURCES-1:0] v;
    v = '0;
    if (id >= 1 && id <= SOURCES) v[id-1] = 1'b1;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_src(input int id, input logic pend, input logic en, input int pri);
    ip[id-1] = pend;
    ie[id-1] = en;
    prio[(id-1)*PRI_BITS +: PRI_BITS] = PRI_BITS'(pri);
  endtask

  // Drive one request cycle, queue the expected strobes, and compare when they appear.
  task automatic do_req(input logic c, input logic p, input int cid, input int exp_claim,
                        input logic [SOURCES-1:0] exp_cmp);
    exp_t e;
    claim_req    = c;
    complete_req = p;
    complete_id  = ID_BITS'(cid);
    sb_q.push_back('{vld: c, id: ID_BITS'(exp_claim), clm: onehot(exp_claim), cmp: exp_cmp});
    tick(1);
    claim_req    = 1'b0;
    complete_req = 1'b0;
    complete_id  = '0;
    e = sb_q.pop_front();
    check("claim_vld", 32'(claim_vld), 32'(e.vld));
    check("claim_id",  32'(claim_id),  32'(e.id));
    check("claim_vec", 32'(claim),     32'(e.clm));
    check("complete",  32'(complete),  32'(e.cmp));
  endtask

  initial begin
    rst_n = 1'b0; ip = '0; ie = '0; prio = '0; threshold = '0;
    claim_req = 1'b0; complete_req = 1'b0; complete_id = '0;
    #1;
    check("rst_irq", 32'(irq), 0);
    check("rst_best", 32'(best_id), 0);
    check("rst_vld", 32'(claim_vld), 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("idle_irq", 32'(irq), 0);
    check("idle_best", 32'(best_id), 0);
    do_req(1'b1, 1'b0, 0, 0, '0);
    tick(2);

    // Two-cycle latency from inputs to irq/best_id, and threshold masking.
    set_src(3, 1'b1, 1'b1, 5);
    threshold = 3'd3;
    tick(1);
    check("lat1_irq", 32'(irq), 0);
    check("lat1_best", 32'(best_id), 0);
    tick(1);
    check("lat2_irq", 32'(irq), 1);
    check("lat2_best", 32'(best_id), 3);
    threshold = 3'd5;
    tick(1);
    check("thr_lat1_irq", 32'(irq), 1);
    tick(1);
    check("thr_lat2_irq", 32'(irq), 0);
    check("thr_best", 32'(best_id), 3);
    threshold = 3'd3;

    // Tie goes to the lowest ID; a higher priority overrides it.
    set_src(4, 1'b1, 1'b1, 6);
    set_src(7, 1'b1, 1'b1, 6);
    tick(2);
    check("tie_best", 32'(best_id), 4);
    set_src(7, 1'b1, 1'b1, 7);
    tick(2);
    check("hi_best", 32'(best_id), 7);
    set_src(9, 1'b1, 1'b0, 7);
    set_src(4, 1'b0, 1'b1, 6);
    set_src(7, 1'b0, 1'b1, 7);
    tick(2);
    check("dis_best", 32'(best_id), 3);
    check("dis_irq", 32'(irq), 1);

    // Claim ID 3; the gateway drops ip once the claim strobe is seen.
    do_req(1'b1, 1'b0, 0, 3, '0);
    check("flush1_irq", 32'(irq), 0);
    ip[2] = 1'b0;
    do_req(1'b1, 1'b0, 0, 0, '0);
    check("flush2_irq", 32'(irq), 0);
    tick(1);
    check("post_irq", 32'(irq), 0);
    check("post_best", 32'(best_id), 0);

    do_req(1'b0, 1'b1, 3, 0, onehot(3));
    do_req(1'b0, 1'b1, 0, 0, '0);
    do_req(1'b0, 1'b1, 17, 0, '0);

    // Completion of ID 5 with and without a prior claim.
    do_req(1'b0, 1'b1, 5, 0, TRACK ? '0 : onehot(5));
    set_src(5, 1'b1, 1'b1, 4);
    tick(2);
    check("id5_best", 32'(best_id), 5);
    do_req(1'b1, 1'b1, 5, 5, TRACK ? '0 : onehot(5));
    ip[4] = 1'b0;
    tick(2);
    do_req(1'b0, 1'b1, 5, 0, onehot(5));
    do_req(1'b0, 1'b1, 5, 0, TRACK ? '0 : onehot(5));

    // Threshold at the top level masks everything, including the claim.
    set_src(5, 1'b1, 1'b1, 7);
    threshold = 3'd7;
    tick(2);
    check("max_thr_irq", 32'(irq), 0);
    check("max_thr_best", 32'(best_id), 5);
    do_req(1'b1, 1'b0, 0, 0, '0);
    tick(2);

    // Asynchronous reset in the middle of a handshake clears strobes at once.
    threshold = 3'd3;
    tick(2);
    check("pre_rst_irq", 32'(irq), 1);
    claim_req = 1'b1; complete_req = 1'b1; complete_id = 5'd5;
    tick(1);
    claim_req = 1'b0; complete_req = 1'b0;
    check("pre_rst_vld", 32'(claim_vld), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vld", 32'(claim_vld), 0);
    check("arst_claim", 32'(claim), 0);
    check("arst_complete", 32'(complete), 0);
    check("arst_irq", 32'(irq), 0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    check("rearm_irq", 32'(irq), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
